// File: rtl/io_slink_frame_rd_pkg.sv
// Shared types and constants for the SLINK frame reader.
package io_slink_frame_rd_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned FRAME_W = 18;
    localparam int unsigned SOP_BIT = 17;
    localparam int unsigned EOP_BIT = 16;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ORPHAN = 3'd1;
    localparam logic [2:0] ERR_SOP    = 3'd2;
    localparam logic [2:0] ERR_LEN    = 3'd3;
    localparam logic [2:0] ERR_SUM    = 3'd4;
    localparam logic [2:0] ERR_TMO    = 3'd5;
    localparam logic [2:0] ERR_DST    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PLD,
        ST_SUM,
        ST_DROP
    } state_e;

    // Bit layout matches SOP_BIT/EOP_BIT above.
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [WORD_W-1:0] word;
    } slink_word_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/io_slink_pgctl.sv
// Ping-pong page ownership: busy flags, write page, release/commit arbitration, pop gating.
module io_slink_pgctl (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic       dval,
    input  logic       eop,
    input  logic       commit,
    input  logic [1:0] page_release,
    output logic       rdreq_c,
    output logic       wr_page,
    output logic [1:0] page_busy
);

    logic [1:0] busy_d;

    // Commit wins over a same-cycle release of the page being filled.
    always_comb begin
        busy_d = page_busy & ~page_release;
        if (commit) begin
            busy_d[wr_page] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            page_busy <= 2'b00;
            wr_page   <= 1'b0;
        end else begin
            page_busy <= busy_d;
            if (commit) begin
                wr_page <= ~wr_page;
            end
        end
    end

    // Stop popping once a frame ends while the other page is still held.
    assign rdreq_c = !empty && !page_busy[wr_page] && !(dval && eop && page_busy[~wr_page]);

endmodule

// File: rtl/io_slink_frame_rd.sv
// SLINK frame reader: pops framed words, checks length/checksum, fills ping-pong pages.
// Optional destination filtering under `IO_SLINK_FRAME_DST_CHK_EN.
module io_slink_frame_rd
    import io_slink_frame_rd_pkg::*;
#(
    parameter logic [1:0]  CARD_TYPE = 2'b00,
    parameter int unsigned PAGE_AW   = 9,
    parameter int unsigned MAX_LEN   = 256,
    parameter int unsigned TMO_CYC   = 1000
) (
    input  logic               clk_125m,
    input  logic               rst_125m,
    input  logic               slink_mm_empty,
    input  logic               slink_mm_dval,
    input  logic [17:0]        slink_mm_data,
    output logic               mm_slink_rdreq,
    input  logic [7:0]         self_addr,
    output logic               ram_wr_en,
    output logic [PAGE_AW:0]   ram_wr_addr,
    output logic [15:0]        ram_wr_data,
    output logic               frm_rdy,
    output logic               frm_page,
    output logic [15:0]        frm_len,
    output logic [7:0]         frm_type,
    input  logic [1:0]         page_release,
    output logic [1:0]         page_busy,
    output logic               frm_err,
    output logic [2:0]         err_code,
    output logic [15:0]        frm_ok_cnt,
    output logic [15:0]        err_cnt
);

    localparam int unsigned IDX_W = PAGE_AW + 1;
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    slink_word_t       rx;
    logic              rdreq_c;
    logic              wr_page;
    logic              commit_c;
    logic              drop_c;
    logic              dst_bad_c;
    logic              unused_ok;
    logic [2:0]        code_c;
    state_e            state_q, state_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic [WORD_W-1:0] len_q, len_d;
    logic [WORD_W-1:0] w0_q, w0_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_en_d;
    logic [IDX_W-1:0]  wr_addr_d;
    logic [WORD_W-1:0] wr_data_d;

    assign rx             = slink_mm_data;
    assign mm_slink_rdreq = rdreq_c;

`ifdef IO_SLINK_FRAME_DST_CHK_EN
    assign dst_bad_c = (w0_q[15:8] != self_addr) && (w0_q[15:8] != 8'hFF);
    assign unused_ok = ^{1'b0, CARD_TYPE};
`else
    assign dst_bad_c = 1'b0;
    assign unused_ok = ^{1'b0, CARD_TYPE, self_addr, w0_q[15:8]};
`endif

    io_slink_pgctl u_pgctl (
        .clk          (clk_125m),
        .rst          (rst_125m),
        .empty        (slink_mm_empty),
        .dval         (slink_mm_dval),
        .eop          (rx.eop),
        .commit       (commit_c),
        .page_release (page_release),
        .rdreq_c      (rdreq_c),
        .wr_page      (wr_page),
        .page_busy    (page_busy)
    );

    // Frame parser: next state, datapath updates and commit/drop decisions.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        len_d     = len_q;
        w0_d      = w0_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = ram_wr_addr;
        wr_data_d = ram_wr_data;
        commit_c  = 1'b0;
        drop_c    = 1'b0;
        code_c    = ERR_NONE;

        if (slink_mm_dval) begin
            tmo_d = '0;
            if (rx.sop) begin
                // Any sop restarts parsing; inside a frame it also drops the old one.
                if (state_q != ST_IDLE) begin
                    drop_c = 1'b1;
                    code_c = ERR_SOP;
                end
                state_d = ST_HDR;
                sum_d   = rx.word;
                w0_d    = rx.word;
                idx_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        drop_c = 1'b1;
                        code_c = ERR_ORPHAN;
                    end
                    ST_HDR: begin
                        sum_d = sum_q + rx.word;
                        len_d = rx.word;
                        if (rx.eop || (rx.word > WORD_W'(MAX_LEN))) begin
                            drop_c  = 1'b1;
                            code_c  = ERR_LEN;
                            state_d = ST_IDLE;
                        end else if (dst_bad_c) begin
                            state_d = ST_DROP;
                        end else if (rx.word == '0) begin
                            state_d = ST_SUM;
                        end else begin
                            state_d = ST_PLD;
                        end
                    end
                    ST_PLD: begin
                        if (rx.eop) begin
                            drop_c  = 1'b1;
                            code_c  = ERR_LEN;
                            state_d = ST_IDLE;
                        end else begin
                            sum_d     = sum_q + rx.word;
                            wr_en_d   = 1'b1;
                            wr_addr_d = {wr_page, idx_q[PAGE_AW-1:0]};
                            wr_data_d = rx.word;
                            idx_d     = idx_q + IDX_W'(1);
                            if ((WORD_W'(idx_q) + WORD_W'(1)) == len_q) begin
                                state_d = ST_SUM;
                            end
                        end
                    end
                    ST_SUM: begin
                        state_d = ST_IDLE;
                        if (!rx.eop) begin
                            drop_c = 1'b1;
                            code_c = ERR_LEN;
                        end else if (rx.word != sum_q) begin
                            drop_c = 1'b1;
                            code_c = ERR_SUM;
                        end else begin
                            commit_c = 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (rx.eop) begin
                            drop_c  = 1'b1;
                            code_c  = ERR_DST;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                drop_c  = 1'b1;
                code_c  = ERR_TMO;
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if (drop_c && !rx.sop) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk_125m) begin
        if (rst_125m) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            len_q       <= '0;
            w0_q        <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            frm_rdy     <= 1'b0;
            frm_page    <= 1'b0;
            frm_len     <= '0;
            frm_type    <= '0;
            frm_err     <= 1'b0;
            err_code    <= '0;
            frm_ok_cnt  <= '0;
            err_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            w0_q        <= w0_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            ram_wr_en   <= wr_en_d;
            ram_wr_addr <= wr_addr_d;
            ram_wr_data <= wr_data_d;
            frm_rdy     <= commit_c;
            frm_err     <= drop_c;
            if (commit_c) begin
                frm_page   <= wr_page;
                frm_len    <= len_q;
                frm_type   <= w0_q[7:0];
                frm_ok_cnt <= sat_inc(frm_ok_cnt);
            end
            if (drop_c) begin
                err_code <= code_c;
                err_cnt  <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_io_slink_frame_rd.sv
// Scoreboard bench for io_slink_frame_rd: buffer model feeds frames, monitor pops expectations.
module tb_io_slink_frame_rd;

    logic        clk_125m = 1'b0;
    logic        rst_125m = 1'b1;
    logic        slink_mm_empty;
    logic        slink_mm_dval;
    logic [17:0] slink_mm_data;
    logic        mm_slink_rdreq;
    logic [7:0]  self_addr;
    logic        ram_wr_en;
    logic [9:0]  ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic        frm_rdy;
    logic        frm_page;
    logic [15:0] frm_len;
    logic [7:0]  frm_type;
    logic [1:0]  page_release;
    logic [1:0]  page_busy;
    logic        frm_err;
    logic [2:0]  err_code;
    logic [15:0] frm_ok_cnt;
    logic [15:0] err_cnt;

    logic [17:0] fifo[$];
    logic [25:0] exp_wr[$];
    logic [24:0] exp_frm[$];
    logic [2:0]  exp_err[$];

    int   n_vec = 0;
    int   n_miss = 0;
    int   n_ok_exp = 0;
    int   n_err_exp = 0;
    int   n_ok_seen = 0;
    int   n_err_seen = 0;
    logic exp_page = 1'b0;
    logic [2:0] last_code = 3'd0;

    always #4 clk_125m = ~clk_125m;

    io_slink_frame_rd dut (
        .clk_125m       (clk_125m),
        .rst_125m       (rst_125m),
        .slink_mm_empty (slink_mm_empty),
        .slink_mm_dval  (slink_mm_dval),
        .slink_mm_data  (slink_mm_data),
        .mm_slink_rdreq (mm_slink_rdreq),
        .self_addr      (self_addr),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .frm_rdy        (frm_rdy),
        .frm_page       (frm_page),
        .frm_len        (frm_len),
        .frm_type       (frm_type),
        .page_release   (page_release),
        .page_busy      (page_busy),
        .frm_err        (frm_err),
        .err_code       (err_code),
        .frm_ok_cnt     (frm_ok_cnt),
        .err_cnt        (err_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receive buffer model: word popped on rdreq is presented with dval the next cycle.
    logic        pend;
    logic [17:0] nxt;
    initial begin
        slink_mm_empty = 1'b1;
        slink_mm_dval  = 1'b0;
        slink_mm_data  = '0;
        pend = 1'b0;
        nxt  = '0;
        forever begin
            @(negedge clk_125m);
            pend = mm_slink_rdreq;
            if (pend) begin
                if (fifo.size() > 0) begin
                    nxt = fifo.pop_front();
                end else begin
                    check_val("rd_when_empty", 1, 0);
                    pend = 1'b0;
                end
            end
            @(posedge clk_125m);
            #1;
            slink_mm_dval  = pend;
            slink_mm_data  = pend ? nxt : 18'h0;
            slink_mm_empty = (fifo.size() == 0);
        end
    end

    logic [25:0] m_wr;
    logic [24:0] m_frm;
    logic [2:0]  m_err;
    always @(negedge clk_125m) begin
        if (!rst_125m) begin
            if (ram_wr_en) begin
                if (exp_wr.size() == 0) begin
                    check_val("wr_unexpected", 1, 0);
                end else begin
                    m_wr = exp_wr.pop_front();
                    check_val("wr_addr", 32'(ram_wr_addr), 32'(m_wr[25:16]));
                    check_val("wr_data", 32'(ram_wr_data), 32'(m_wr[15:0]));
                end
            end
            if (frm_rdy) begin
                if (exp_frm.size() == 0) begin
                    check_val("frm_unexpected", 1, 0);
                end else begin
                    m_frm = exp_frm.pop_front();
                    n_ok_seen++;
                    check_val("frm_page", 32'(frm_page), 32'(m_frm[24]));
                    check_val("frm_len", 32'(frm_len), 32'(m_frm[23:8]));
                    check_val("frm_type", 32'(frm_type), 32'(m_frm[7:0]));
                    check_val("frm_ok_cnt", 32'(frm_ok_cnt), 32'(n_ok_seen));
                end
            end
            if (frm_err) begin
                if (exp_err.size() == 0) begin
                    check_val("err_unexpected", 1, 0);
                end else begin
                    m_err = exp_err.pop_front();
                    n_err_seen++;
                    check_val("err_code", 32'(err_code), 32'(m_err));
                    check_val("err_cnt", 32'(err_cnt), 32'(n_err_seen));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_125m);
            #1;
        end
    endtask

    task automatic push_w(input logic s, input logic e, input logic [15:0] w);
        fifo.push_back({s, e, w});
    endtask

    task automatic expect_err(input logic [2:0] code);
        exp_err.push_back(code);
        n_err_exp++;
        last_code = code;
    endtask

    task automatic expect_wr(input int idx, input logic [15:0] w);
        exp_wr.push_back({exp_page, 9'(idx), w});
    endtask

    // code 0 means the frame must commit; otherwise the expected drop code.
    task automatic send_frame(input logic [7:0] dst, input logic [7:0] typ, input logic [15:0] len,
                              input logic [15:0] base, input logic [15:0] sum_adj,
                              input bit wr_exp, input logic [2:0] code);
        logic [15:0] sum;
        logic [15:0] w;
        sum = {dst, typ};
        push_w(1'b1, 1'b0, {dst, typ});
        sum = sum + len;
        push_w(1'b0, 1'b0, len);
        for (int i = 0; i < int'(len); i++) begin
            w   = base + 16'(i);
            sum = sum + w;
            push_w(1'b0, 1'b0, w);
            if (wr_exp) expect_wr(i, w);
        end
        push_w(1'b0, 1'b1, sum + sum_adj);
        if (code == 3'd0) begin
            exp_frm.push_back({exp_page, len, typ});
            exp_page = ~exp_page;
            n_ok_exp++;
        end else begin
            expect_err(code);
        end
    endtask

    task automatic wait_q(input int f, input int w, input int e, input int q, input string tag);
        int n;
        n = 0;
        while (!(exp_frm.size() <= f && exp_wr.size() <= w && exp_err.size() <= e && fifo.size() <= q)
               && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) check_val({tag, "_timeout"}, 1, 0);
        tick(3);
    endtask

    task automatic release_pg(input logic [1:0] m);
        page_release = m;
        tick(1);
        page_release = 2'b00;
        tick(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        self_addr    = 8'h12;
        page_release = 2'b00;
        tick(4);
        rst_125m = 1'b0;

        @(negedge clk_125m);
        check_val("rst_frm_rdy", 32'(frm_rdy), 0);
        check_val("rst_frm_err", 32'(frm_err), 0);
        check_val("rst_err_code", 32'(err_code), 0);
        check_val("rst_page_busy", 32'(page_busy), 0);
        check_val("rst_ok_cnt", 32'(frm_ok_cnt), 0);
        check_val("rst_err_cnt", 32'(err_cnt), 0);
        check_val("rst_wr_en", 32'(ram_wr_en), 0);
        check_val("rst_rdreq", 32'(mm_slink_rdreq), 0);
        tick(1);

        // Single good frame into page 0.
        send_frame(8'h00, 8'h5A, 16'd4, 16'd1, 16'd0, 1'b1, 3'd0);
        wait_q(0, 0, 0, 0, "f1");
        @(negedge clk_125m);
        check_val("f1_busy", 32'(page_busy), 32'h1);
        check_val("f1_ok_cnt", 32'(frm_ok_cnt), 1);
        tick(1);

        // Back-to-back: second to page 1, third must wait for a release.
        send_frame(8'h00, 8'h21, 16'd3, 16'h0100, 16'd0, 1'b1, 3'd0);
        send_frame(8'h00, 8'h22, 16'd4, 16'h0200, 16'd0, 1'b1, 3'd0);
        wait_q(1, 4, 0, 7, "f2");
        tick(20);
        @(negedge clk_125m);
        check_val("blk_rdreq", 32'(mm_slink_rdreq), 0);
        check_val("blk_fifo_held", 32'(fifo.size()), 7);
        check_val("blk_busy", 32'(page_busy), 32'h3);
        tick(1);
        release_pg(2'b01);
        wait_q(0, 0, 0, 0, "f3");
        @(negedge clk_125m);
        check_val("f3_busy", 32'(page_busy), 32'h3);
        tick(1);
        release_pg(2'b11);
        @(negedge clk_125m);
        check_val("rel_busy", 32'(page_busy), 32'h0);
        tick(1);
        release_pg(2'b10);
        @(negedge clk_125m);
        check_val("rel_idle_busy", 32'(page_busy), 32'h0);
        tick(1);

        // Checksum off by one.
        send_frame(8'h00, 8'h77, 16'd3, 16'h0300, 16'd1, 1'b1, 3'd4);
        wait_q(0, 0, 0, 0, "sum");
        @(negedge clk_125m);
        check_val("sum_busy", 32'(page_busy), 32'h0);
        check_val("sum_err_cnt", 32'(err_cnt), 1);
        tick(1);

        // sop at the third payload word restarts with the new frame.
        push_w(1'b1, 1'b0, 16'h0044);
        push_w(1'b0, 1'b0, 16'd5);
        push_w(1'b0, 1'b0, 16'h0400);
        push_w(1'b0, 1'b0, 16'h0401);
        expect_wr(0, 16'h0400);
        expect_wr(1, 16'h0401);
        expect_err(3'd2);
        send_frame(8'h00, 8'h55, 16'd2, 16'h0900, 16'd0, 1'b1, 3'd0);
        wait_q(0, 0, 0, 0, "sop");
        release_pg(2'b10);

        // Stall mid-payload until the inactivity timeout.
        push_w(1'b1, 1'b0, 16'h0011);
        push_w(1'b0, 1'b0, 16'd4);
        push_w(1'b0, 1'b0, 16'h0500);
        push_w(1'b0, 1'b0, 16'h0501);
        expect_wr(0, 16'h0500);
        expect_wr(1, 16'h0501);
        wait_q(0, 0, 0, 0, "stall");
        tick(900);
        expect_err(3'd5);
        wait_q(0, 0, 0, 0, "tmo");

        // Oversized length, orphan word, early eop.
        push_w(1'b1, 1'b0, 16'h0022);
        push_w(1'b0, 1'b0, 16'd300);
        expect_err(3'd3);
        wait_q(0, 0, 0, 0, "len");
        push_w(1'b0, 1'b0, 16'hBEEF);
        expect_err(3'd1);
        wait_q(0, 0, 0, 0, "orphan");
        push_w(1'b1, 1'b0, 16'h0033);
        push_w(1'b0, 1'b0, 16'd3);
        push_w(1'b0, 1'b0, 16'h0700);
        push_w(1'b0, 1'b1, 16'h0701);
        expect_wr(0, 16'h0700);
        expect_err(3'd3);
        wait_q(0, 0, 0, 0, "eop_early");

        // Zero-length frame.
        send_frame(8'h00, 8'h30, 16'd0, 16'd0, 16'd0, 1'b1, 3'd0);
        wait_q(0, 0, 0, 0, "len0");
        release_pg(2'b01);

        // Destination filtering.
`ifdef IO_SLINK_FRAME_DST_CHK_EN
        send_frame(8'h34, 8'h66, 16'd3, 16'h0A00, 16'd0, 1'b0, 3'd6);
`else
        send_frame(8'h34, 8'h66, 16'd3, 16'h0A00, 16'd0, 1'b1, 3'd0);
`endif
        send_frame(8'hFF, 8'h67, 16'd2, 16'h0B00, 16'd0, 1'b1, 3'd0);
        wait_q(0, 0, 0, 0, "dst");

        @(negedge clk_125m);
        check_val("end_ok_cnt", 32'(frm_ok_cnt), 32'(n_ok_exp));
        check_val("end_err_cnt", 32'(err_cnt), 32'(n_err_exp));
        check_val("end_err_code", 32'(err_code), 32'(last_code));
        check_val("end_frm_q", 32'(exp_frm.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
